// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and constants for the PLL reset sequencer.
// Holds the sequencer state enum, the pll_enclk and lol_cnt widths,
// and a saturating increment helper for the loss-of-lock counter.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    ENABLE,
    RUN,
    FAULT
  } pll_state_e;

  localparam int LOL_CNT_W = 8;
  localparam int ENCLK_W   = 3;

  function automatic logic [LOL_CNT_W-1:0] sat_inc(
    input logic [LOL_CNT_W-1:0] v
  );
    return (&v) ? v : v + LOL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
// Ports: clk, rst_n (sync, active low, clears both stages),
//        d (async input), q (synchronized output, 2-cycle latency).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL bring-up / reset sequencer. Pulses the PLL reset,
// qualifies lock, staggers the clock enables, then releases SoC reset.
// Retries on lock timeout, recovers from loss of lock.
// Ports: clk, rst_n (sync, active low), pll_lock (async),
//   soft_restart (pulse) in; pll_reset, pll_enclk[2:0], sys_rst_n,
//   ready, fault, lol_cnt[7:0] out. All outputs are registered.
// Macro PLL_SEQ_LOL_CNT_EN builds the loss-of-lock counter;
// without it lol_cnt is tied to zero.
module pll_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int EN_STAGGER_CYCLES   = 8,
  parameter int MAX_RETRY           = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_lock,
  input  logic                 soft_restart,
  output logic                 pll_reset,
  output logic [ENCLK_W-1:0]   pll_enclk,
  output logic                 sys_rst_n,
  output logic                 ready,
  output logic                 fault,
  output logic [LOL_CNT_W-1:0] lol_cnt
);

  localparam int RW = $clog2(PLL_RST_CYCLES) + 1;
  localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
  localparam int EW = $clog2(3 * EN_STAGGER_CYCLES) + 1;
  localparam int YW = $clog2(MAX_RETRY) + 1;

  localparam logic [RW-1:0] RST_LAST =
    RW'(PLL_RST_CYCLES - 1);
  localparam logic [SW-1:0] STB_DONE =
    SW'(LOCK_STABLE_CYCLES);
  localparam logic [TW-1:0] TO_DONE =
    TW'(LOCK_TIMEOUT_CYCLES);
  localparam logic [EW-1:0] EN_B1 =
    EW'(EN_STAGGER_CYCLES);
  localparam logic [EW-1:0] EN_B2 =
    EW'(2 * EN_STAGGER_CYCLES);
  localparam logic [EW-1:0] EN_DONE =
    EW'(3 * EN_STAGGER_CYCLES);
  localparam logic [YW-1:0] RETRY_MAX =
    YW'(MAX_RETRY);

  logic lock_s;

  pll_state_e state_q;
  pll_state_e state_d;

  logic [RW-1:0] rst_cnt_q;
  logic [RW-1:0] rst_cnt_d;
  logic [SW-1:0] stb_cnt_q;
  logic [SW-1:0] stb_cnt_d;
  logic [TW-1:0] to_cnt_q;
  logic [TW-1:0] to_cnt_d;
  logic [EW-1:0] en_cnt_q;
  logic [EW-1:0] en_cnt_d;
  logic [YW-1:0] retry_q;
  logic [YW-1:0] retry_d;

  logic               pll_reset_q;
  logic               pll_reset_d;
  logic [ENCLK_W-1:0] enclk_q;
  logic [ENCLK_W-1:0] enclk_d;
  logic               sys_rst_n_q;
  logic               sys_rst_n_d;
  logic               ready_q;
  logic               ready_d;
  logic               fault_q;
  logic               fault_d;

  logic lol_inc;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Counters default to zero so each one starts cleared
  // on entry to the state that uses it.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = '0;
    stb_cnt_d = '0;
    to_cnt_d  = '0;
    en_cnt_d  = '0;
    retry_d   = retry_q;
    lol_inc   = 1'b0;

    if (soft_restart) begin
      state_d = RESET_PLL;
      retry_d = '0;
    end else begin
      unique case (state_q)
        RESET_PLL: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
          end else begin
            rst_cnt_d = rst_cnt_q + RW'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock qualification wins over a coincident timeout.
          if (stb_cnt_q == STB_DONE) begin
            state_d = ENABLE;
          end else if (to_cnt_q == TO_DONE) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + YW'(1);
              state_d = RESET_PLL;
            end else begin
              state_d = FAULT;
            end
          end else begin
            to_cnt_d  = to_cnt_q + TW'(1);
            stb_cnt_d = lock_s ? stb_cnt_q + SW'(1) : '0;
          end
        end
        ENABLE: begin
          if (!lock_s) begin
            state_d = RESET_PLL;
          end else begin
            en_cnt_d = en_cnt_q + EW'(1);
            if (en_cnt_d == EN_DONE) begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          retry_d = '0;
          if (!lock_s) begin
            state_d = RESET_PLL;
            lol_inc = 1'b1;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = RESET_PLL;
        end
      endcase
    end

    // Outputs follow the next state so they register
    // on the same edge as the state change.
    pll_reset_d = (state_d == RESET_PLL) ||
                  (state_d == FAULT);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
    enclk_d     = '0;
    if (state_d == RUN) begin
      enclk_d = '1;
    end else if (state_d == ENABLE) begin
      enclk_d = {en_cnt_d >= EN_B2,
                 en_cnt_d >= EN_B1,
                 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      rst_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      to_cnt_q    <= '0;
      en_cnt_q    <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      enclk_q     <= '0;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      to_cnt_q    <= to_cnt_d;
      en_cnt_q    <= en_cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      enclk_q     <= enclk_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign pll_enclk = enclk_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fault     = fault_q;

`ifdef PLL_SEQ_LOL_CNT_EN
  logic [LOL_CNT_W-1:0] lol_cnt_q;
  logic [LOL_CNT_W-1:0] lol_cnt_d;

  // soft_restart keeps the count; only rst_n clears it.
  always_comb begin
    lol_cnt_d = lol_cnt_q;
    if (lol_inc) begin
      lol_cnt_d = sat_inc(lol_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lol_cnt_q <= '0;
    end else begin
      lol_cnt_q <= lol_cnt_d;
    end
  end

  assign lol_cnt = lol_cnt_q;
`else
  logic lol_inc_unused;
  assign lol_inc_unused = lol_inc;
  assign lol_cnt        = '0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: directed and randomized bench for pll_rst_seq,
// checked cycle by cycle against a behavioural model of the sequence.
module tb_pll_rst_seq;

  localparam int PRC  = 4;
  localparam int STB  = 8;
  localparam int TO   = 64;
  localparam int STG  = 2;
  localparam int MAXR = 2;

`ifdef PLL_SEQ_LOL_CNT_EN
  localparam int LOL_ON = 1;
`else
  localparam int LOL_ON = 0;
`endif

  localparam int P_RST   = 0;
  localparam int P_WAIT  = 1;
  localparam int P_EN    = 2;
  localparam int P_RUN   = 3;
  localparam int P_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       soft_restart;
  logic       pll_reset;
  logic [2:0] pll_enclk;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [7:0] lol_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // model state: phase, edges spent in phase, run of good
  // lock samples, retries used, loss-of-lock events
  int ph   = P_RST;
  int t    = 0;
  int good = 0;
  int att  = 0;
  int lol  = 0;
  int l1   = 0;
  int l2   = 0;

  always #5 clk = ~clk;

  pll_rst_seq #(
    .PLL_RST_CYCLES      (PRC),
    .LOCK_STABLE_CYCLES  (STB),
    .LOCK_TIMEOUT_CYCLES (TO),
    .EN_STAGGER_CYCLES   (STG),
    .MAX_RETRY           (MAXR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .soft_restart (soft_restart),
    .pll_reset    (pll_reset),
    .pll_enclk    (pll_enclk),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .fault        (fault),
    .lol_cnt      (lol_cnt)
  );

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One clock edge of the reference sequence.
  task automatic model_step();
    int ls;
    if (!rst_n) begin
      ph = P_RST; t = 0; good = 0;
      att = 0; lol = 0; l1 = 0; l2 = 0;
      return;
    end
    // lock level seen by the sequencer lags the pin by two edges
    ls = l2;
    l2 = l1;
    l1 = int'(pll_lock);
    if (soft_restart) begin
      ph = P_RST; t = 0; good = 0; att = 0;
      return;
    end
    case (ph)
      P_RST: begin
        t++;
        if (t == PRC) begin
          ph = P_WAIT; t = 0; good = 0;
        end
      end
      P_WAIT: begin
        if (good >= STB) begin
          ph = P_EN; t = 0;
        end else if (t >= TO) begin
          if (att < MAXR) begin
            att++; ph = P_RST; t = 0;
          end else begin
            ph = P_FAULT;
          end
        end else begin
          t++;
          good = (ls != 0) ? good + 1 : 0;
        end
      end
      P_EN: begin
        if (ls == 0) begin
          ph = P_RST; t = 0;
        end else begin
          t++;
          if (t == 3 * STG) begin
            ph = P_RUN; t = 0;
          end
        end
      end
      P_RUN: begin
        att = 0;
        if (ls == 0) begin
          ph = P_RST; t = 0;
          if (lol < 255) lol++;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [14:0] model_out();
    logic [2:0] en;
    logic [7:0] lc;
    en = 3'd0;
    if (ph == P_RUN) en = 3'b111;
    if (ph == P_EN) begin
      en[0] = 1'b1;
      en[1] = (t >= STG);
      en[2] = (t >= 2 * STG);
    end
    lc = (LOL_ON != 0) ? 8'(lol) : 8'd0;
    return {ph == P_RST || ph == P_FAULT, en,
            ph == P_RUN, ph == P_RUN, ph == P_FAULT, lc};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (chk_on) begin
        chk("model", 32'({pll_reset, pll_enclk, sys_rst_n,
                          ready, fault, lol_cnt}),
            32'(model_out()));
      end
    end
  end

  function automatic logic [7:0] cur(int sel);
    logic [7:0] r;
    r = '0;
    case (sel)
      0: r[0] = ready;
      1: r[0] = sys_rst_n;
      2: r[2:0] = pll_enclk;
      3: r[0] = fault;
      default: r[0] = pll_enclk[0];
    endcase
    return r;
  endfunction

  // Waits (bounded) for an output to reach a value; the final
  // comparison also flags an expired budget.
  task automatic wait_sig(string tag, int sel, logic [7:0] val,
                          int budget, output int n);
    n = 0;
    while (cur(sel) !== val && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(cur(sel)), 32'(val));
  endtask

  int hi;
  int n;
  int pulses;
  logic prev;
  int dwell;

  initial begin
    rst_n        = 1'b0;
    pll_lock     = 1'b0;
    soft_restart = 1'b0;
    tick();
    chk_on = 1'b1;
    tick();

    chk("rst_pll_reset", 32'(pll_reset), 1);
    chk("rst_enclk", 32'(pll_enclk), 0);
    chk("rst_sys_rst_n", 32'(sys_rst_n), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_lol", 32'(lol_cnt), 0);

    // normal bring-up, lock rises at cycle 10
    rst_n = 1'b1;
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      hi += int'(pll_reset);
      tick();
    end
    chk("pll_reset_width", hi, PRC);
    pll_lock = 1'b1;
    wait_sig("en0_rise", 4, 8'd1, 100, n);
    chk("lock_to_en0", n, 2 + STB + 1);
    chk("enclk_001", 32'(pll_enclk), 1);
    repeat (STG) tick();
    chk("enclk_011", 32'(pll_enclk), 3);
    repeat (STG) tick();
    chk("enclk_111", 32'(pll_enclk), 7);
    chk("sys_early", 32'(sys_rst_n), 0);
    repeat (STG) tick();
    chk("sys_rise", 32'(sys_rst_n), 1);
    chk("ready_rise", 32'(ready), 1);

    // loss of lock in RUN
    repeat (3) tick();
    pll_lock = 1'b0;
    wait_sig("lol_sys", 1, 8'd0, 20, n);
    chk("lol_latency", n, 3);
    chk("lol_enclk", 32'(pll_enclk), 0);
    chk("lol_ready", 32'(ready), 0);
    chk("lol_cnt_1", 32'(lol_cnt), LOL_ON);

    // glitchy lock while waiting
    repeat (6) tick();
    pll_lock = 1'b1;
    repeat (5) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_sig("glitch_en0", 4, 8'd1, 100, n);
    chk("glitch_to_en0", n, 11);
    wait_sig("relock_ready", 0, 8'd1, 60, n);

    // rst_n asserted while enables are 011
    pll_lock = 1'b0;
    wait_sig("mid_sys_low", 1, 8'd0, 20, n);
    repeat (5) tick();
    pll_lock = 1'b1;
    wait_sig("mid_enclk_011", 2, 8'd3, 60, n);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_enclk", 32'(pll_enclk), 0);
    chk("mid_rst_pll_reset", 32'(pll_reset), 1);
    rst_n = 1'b1;
    wait_sig("mid_recover", 0, 8'd1, 100, n);

    // no lock at all: three attempts then FAULT
    pll_lock = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pulses = 0;
    prev = 1'b0;
    n = 0;
    while (!fault && n < 400) begin
      @(negedge clk);
      if (pll_reset && !prev) pulses++;
      prev = pll_reset;
      tick();
      n++;
    end
    chk("nolock_pulses", pulses, MAXR + 1);
    chk("nolock_fault", 32'(fault), 1);
    chk("fault_enclk", 32'(pll_enclk), 0);
    soft_restart = 1'b1;
    tick();
    soft_restart = 1'b0;
    chk("soft_fault_clr", 32'(fault), 0);
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      hi += int'(pll_reset);
      tick();
    end
    chk("soft_pulse_width", hi, PRC);

    // 300 loss-of-lock events
    pll_lock = 1'b1;
    wait_sig("sat_ready0", 0, 8'd1, 200, n);
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      wait_sig("sat_sys_low", 1, 8'd0, 10, n);
      pll_lock = 1'b1;
      wait_sig("sat_ready", 0, 8'd1, 60, n);
    end
    chk("lol_saturate", 32'(lol_cnt), LOL_ON * 255);

    // random lock behaviour, restarts and resets
    dwell = 0;
    for (int c = 0; c < 4000; c++) begin
      if (dwell == 0) begin
        pll_lock = ~pll_lock;
        if ($urandom_range(0, 3) == 0)
          dwell = int'($urandom_range(1, 4));
        else
          dwell = int'($urandom_range(5, 120));
      end else begin
        dwell--;
      end
      soft_restart = ($urandom_range(0, 299) == 0);
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end
    soft_restart = 1'b0;
    rst_n = 1'b1;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_rst_seq.md
# pll_rst_seq

PLL bring-up and reset sequencer that sits directly around the system PLL wrapper. It drives the PLL reset and per-output clock enables, qualifies the asynchronous `lock` signal, and releases the SoC reset only after lock is stable and all clock outputs are enabled. It retries lock acquisition on timeout and recovers automatically from loss of lock.

## Interface
- `PLL_RST_CYCLES`, 16: length of the PLL reset pulse, in cycles.
- `LOCK_STABLE_CYCLES`, 1024: number of consecutive synchronized-high lock samples needed to qualify lock.
- `LOCK_TIMEOUT_CYCLES`, 1000000: lock-wait limit per attempt (20 ms at 50 MHz).
- `EN_STAGGER_CYCLES`, 8: spacing between successive `pll_enclk` bit assertions.
- `MAX_RETRY`, 3: number of re-attempts after timeout before entering FAULT.

Ports:
- `clk` in 1: PLL reference clock (50 MHz).
- `rst_n` in 1: synchronous, active-low reset.
- `pll_lock` in 1: PLL lock, asynchronous to `clk`.
- `soft_restart` in 1: single-cycle pulse that restarts the sequence from any state.
- `pll_reset` out 1: to the PLL `reset` input, active high.
- `pll_enclk` out 3: to PLL `enclk0`..`enclk2`.
- `sys_rst_n` out 1: SoC reset, active low.
- `ready` out 1: high in RUN.
- `fault` out 1: high in FAULT.
- `lol_cnt` out 8: saturating loss-of-lock count.

## Operation
- `pll_lock` passes through a 2-FF synchronizer to give `lock_s`. All outputs are registered.
- Reset values: `pll_reset`=1, `pll_enclk`=0, `sys_rst_n`=0, `ready`=0, `fault`=0, `lol_cnt`=0. The retry count resets to 0 and the state resets to RESET_PLL.
- RESET_PLL
  - `pll_reset`=1, `pll_enclk`=0, `sys_rst_n`=0.
  - After `PLL_RST_CYCLES` cycles, go to WAIT_LOCK.
- WAIT_LOCK
  - `pll_reset`=0.
  - The stable counter increments while `lock_s`=1 and clears on `lock_s`=0.
  - When the stable counter reaches `LOCK_STABLE_CYCLES`, go to ENABLE.
  - When the timeout counter reaches `LOCK_TIMEOUT_CYCLES`: if retry < `MAX_RETRY`, increment retry and go to RESET_PLL; otherwise go to FAULT.
  - If stable and timeout complete in the same cycle, stable wins.
- ENABLE
  - On entry, set `pll_enclk[0]`; set bit 1 `EN_STAGGER_CYCLES` later and bit 2 `2*EN_STAGGER_CYCLES` later.
  - At `3*EN_STAGGER_CYCLES` after entry, go to RUN.
  - If `lock_s`=0 at any point, drop all enables and go to RESET_PLL. This does not consume a retry.
- RUN
  - `sys_rst_n`=1, `ready`=1, retry cleared.
  - If `lock_s`=0: go to RESET_PLL. On the next edge, `sys_rst_n`=0, `pll_enclk`=0, `ready`=0 and `lol_cnt` increments, saturating at 255.
- FAULT
  - `fault`=1, `pll_reset`=1, `pll_enclk`=0, `sys_rst_n`=0.
  - Exits only on `soft_restart` or `rst_n`.
- `soft_restart` in any state: go to RESET_PLL, clear retry and all counters, clear `fault`. `lol_cnt` is kept.
- `soft_restart` coinciding with a state transition: `soft_restart` has priority.
- `rst_n` low mid-sequence: all outputs return to their reset values on the next edge.

## Timing
- `pll_reset` is high for exactly `PLL_RST_CYCLES` cycles after `rst_n` rises.
- Synchronizer latency is 2 cycles.
- `pll_enclk[0]` rises `2 + LOCK_STABLE_CYCLES + 1` cycles after a `pll_lock` rise that occurs during WAIT_LOCK.
- `sys_rst_n` rises `3*EN_STAGGER_CYCLES` cycles after `pll_enclk[0]` rises.
- Loss of lock in RUN: `sys_rst_n` falls 3 cycles after `pll_lock` falls (2 synchronizer + 1 register).
- Counter widths are `$clog2` of their parameter plus 1. No wrap: every counter is compared and cleared.

## Configuration
- `PLL_SEQ_LOL_CNT_EN` defined: the `lol_cnt` register and increment logic are built.
- Undefined: `lol_cnt` is tied to 8'd0 and no register is inferred. All other behaviour is identical.

## Structure
- Shared package `pll_seq_pkg` holds:
  - the state enum (RESET_PLL, WAIT_LOCK, ENABLE, RUN, FAULT);
  - `LOL_CNT_W`=8;
  - the `pll_enclk` width of 3.
- One sub-module, `sync_2ff`, provides the lock synchronizer.

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=64, `EN_STAGGER_CYCLES`=2, `MAX_RETRY`=2.
- **Normal bring-up.** Release `rst_n`, raise `pll_lock` at cycle 10.
  - `pll_reset` is high for 4 cycles.
  - `pll_enclk` steps 001→011→111 at 2-cycle spacing.
  - `sys_rst_n`=1 and `ready`=1 six cycles after `pll_enclk[0]` rises.
- **Glitchy lock.** Pulse `pll_lock` high for 5 cycles, low for 1, then hold high.
  - The stable count restarts; `pll_enclk[0]` rises 11 cycles after the final rise.
- **No lock.** Hold `pll_lock`=0.
  - Three `pll_reset` pulses are seen.
  - `fault`=1 after the third timeout.
  - `soft_restart` clears `fault` and produces a new 4-cycle `pll_reset` pulse.
- **Loss of lock in RUN.** Drop `pll_lock` while in RUN.
  - `sys_rst_n`=0 and `pll_enclk`=0 three cycles after the fall.
  - `lol_cnt`=1 with the macro defined, 0 without it.
  - Re-lock returns the block to RUN.
- **Reset mid-ENABLE.** Assert `rst_n`=0 while `pll_enclk`=011.
  - Next edge: `pll_enclk`=0 and `pll_reset`=1.
- **Saturation.** Cause 300 loss-of-lock events with the macro defined.
  - `lol_cnt` holds at 255.
